// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner: column drive codes,
// per-frame result encoding and the column/frame merge logic.
package keypad_pkg;

    localparam logic [3:0] COL3 = 4'b0111;
    localparam logic [3:0] COL2 = 4'b1011;
    localparam logic [3:0] COL1 = 4'b1101;
    localparam logic [3:0] COL0 = 4'b1110;

    typedef enum logic [1:0] {
        RES_NONE  = 2'd0,
        RES_KEY   = 2'd1,
        RES_MULTI = 2'd2
    } res_kind_e;

    typedef struct packed {
        res_kind_e  kind;
        logic [3:0] code;
    } frame_res_t;

    // Code is kept at zero for NONE/MULTI so whole-struct compares are meaningful.
    localparam frame_res_t RES_NONE_V = '{kind: RES_NONE, code: 4'd0};

    function automatic logic [1:0] col_index(input logic [3:0] col);
        logic [1:0] idx;
        case (col)
            COL3:    idx = 2'd3;
            COL2:    idx = 2'd2;
            COL1:    idx = 2'd1;
            COL0:    idx = 2'd0;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

    function automatic logic [3:0] next_col(input logic [3:0] col);
        logic [3:0] nxt;
        case (col)
            COL3:    nxt = COL2;
            COL2:    nxt = COL1;
            COL1:    nxt = COL0;
            COL0:    nxt = COL3;
            default: nxt = COL3;
        endcase
        return nxt;
    endfunction

    // Fold one column's active-low row sample into the running frame result.
    function automatic frame_res_t merge_column(input frame_res_t acc,
                                                input logic [1:0] c,
                                                input logic [3:0] low);
        frame_res_t res;
        logic [2:0] n;
        logic [1:0] r;
        n = 3'd0;
        r = 2'd0;
        for (int i = 0; i < 4; i++) begin
            n = n + {2'b00, low[i]};
            r = low[i] ? 2'(i) : r;
        end
        if (n == 3'd0) begin
            res = acc;
        end else if ((n == 3'd1) && (acc.kind == RES_NONE)) begin
            res.kind = RES_KEY;
            res.code = {c, r};
        end else begin
            res.kind = RES_MULTI;
            res.code = 4'd0;
        end
        return res;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad-side bundle: row sense lines, column drive and decoded key outputs.
interface keypad_scanner_if;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;

    modport master (input row, output col, output key_code, output key_valid, output key_down);
    modport slave  (output row, input col, input key_code, input key_valid, input key_down);
endinterface

// File: rtl/keypad_debounce.sv
// Frame-level debouncer: a new frame result must repeat DEBOUNCE times before
// it becomes the stable state; new stable single keys produce a one-cycle pulse.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_valid_i,
    input  frame_res_t frame_res_i,
    output logic       key_valid_o,
    output logic [3:0] key_code_o,
    output logic       key_down_o
);

    localparam logic [3:0] DB_MAX = 4'(DEBOUNCE);

    frame_res_t cand_q, cand_d;
    frame_res_t stable_q, stable_d;
    logic [3:0] cnt_q, cnt_d;
    logic       valid_q, valid_d;
    logic [3:0] code_q, code_d;
    logic       down_q, down_d;
    logic       settle_s;

    // Candidate/count update and stable-state change detection.
    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        valid_d  = 1'b0;
        code_d   = code_q;
        down_d   = down_q;
        settle_s = 1'b0;

        if (frame_valid_i) begin
            if (frame_res_i == cand_q) begin
                if (cnt_q != DB_MAX) begin
                    cnt_d    = cnt_q + 4'd1;
                    settle_s = ((cnt_q + 4'd1) == DB_MAX);
                end else begin
                    cnt_d = cnt_q;
                end
            end else begin
                cand_d   = frame_res_i;
                cnt_d    = 4'd1;
                settle_s = (DB_MAX == 4'd1);
            end
        end else begin
            settle_s = 1'b0;
        end

        if (settle_s && (cand_d != stable_q)) begin
            stable_d = cand_d;
            if (cand_d.kind == RES_KEY) begin
                valid_d = 1'b1;
                code_d  = cand_d.code;
                down_d  = 1'b1;
            end else begin
                down_d = 1'b0;
            end
        end else begin
            stable_d = stable_q;
        end
    end

    // Debounce state and registered key outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_q   <= RES_NONE_V;
            stable_q <= RES_NONE_V;
            cnt_q    <= 4'd0;
            valid_q  <= 1'b0;
            code_q   <= 4'd0;
            down_q   <= 1'b0;
        end else begin
            cand_q   <= cand_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            code_q   <= code_d;
            down_q   <= down_d;
        end
    end

    assign key_valid_o = valid_q;
    assign key_code_o  = code_q;
    assign key_down_o  = down_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row synchronizer, column rotation divider and
// per-frame result assembly feeding the debouncer.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int DEBOUNCE = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    keypad_scanner_if.master  kp
);

    localparam int               DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [3:0]       row_meta_q;
    logic [3:0]       row_sync_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       col_q, col_d;
    frame_res_t       acc_q, acc_d;
    frame_res_t       col_res_s;
    logic             sample_s;
    logic             frame_end_s;

    // Two-flop synchronizer for the asynchronous row lines (idle high).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
        end else begin
            row_meta_q <= kp.row;
            row_sync_q <= row_meta_q;
        end
    end

    // Divider, column rotation and frame accumulation next-state.
    always_comb begin
        sample_s    = (div_q == DIV_LAST);
        col_res_s   = merge_column(acc_q, col_index(col_q), ~row_sync_q);
        frame_end_s = sample_s && (col_q == COL0);
        if (sample_s) begin
            div_d = {DIV_W{1'b0}};
            col_d = next_col(col_q);
            acc_d = frame_end_s ? RES_NONE_V : col_res_s;
        end else begin
            div_d = div_q + DIV_W'(1);
            col_d = col_q;
            acc_d = acc_q;
        end
    end

    // Scan state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= {DIV_W{1'b0}};
            col_q <= COL3;
            acc_q <= RES_NONE_V;
        end else begin
            div_q <= div_d;
            col_q <= col_d;
            acc_q <= acc_d;
        end
    end

    assign kp.col = col_q;

    keypad_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
        .clk           (clk),
        .rst_n         (rst_n),
        .frame_valid_i (frame_end_s),
        .frame_res_i   (col_res_s),
        .key_valid_o   (kp.key_valid),
        .key_code_o    (kp.key_code),
        .key_down_o    (kp.key_down)
    );

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner at SCAN_DIV=4, DEBOUNCE=2 using a
// pressed-key matrix model, a table of frame-aligned steps and a pulse scoreboard.
module tb_keypad_scanner;

    localparam int FRAME = 16;

    typedef struct {
        logic [15:0] keys;
        int          frames;
        bit          pulse;
        logic [3:0]  code;
        bit          down;
        string       name;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] pressed;
    logic [3:0]  row_s;
    logic [3:0]  col_tab [4];
    logic [3:0]  exp_q [$];
    vec_t        vecs [$];
    int          n_vec = 0;
    int          n_err = 0;

    keypad_scanner_if kp();

    keypad_scanner #(
        .SCAN_DIV (4),
        .DEBOUNCE (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kp    (kp)
    );

    always #5 clk = ~clk;

    // Matrix model: row r pulled low when a pressed key sits on the driven column.
    always_comb begin
        row_s = 4'hF;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (pressed[4*c+r] && !kp.col[c]) row_s[r] = 1'b0;
            end
        end
    end
    assign kp.row = row_s;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] key(input int k);
        logic [15:0] one;
        one = 16'h0001;
        return one << k;
    endfunction

    function automatic vec_t mk(input logic [15:0] keys, input int frames, input bit pulse,
                                input logic [3:0] code, input bit down, input string name);
        vec_t v;
        v.keys = keys; v.frames = frames; v.pulse = pulse;
        v.code = code; v.down = down; v.name = name;
        return v;
    endfunction

    // Scoreboard: every key_valid pulse must match the oldest expected code.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && kp.key_valid === 1'b1) begin
            check("pulse_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                check("pulse_code", 32'(kp.key_code), 32'(exp_q.pop_front()));
                check("pulse_down", 32'(kp.key_down), 32'd1);
            end
        end
    end

    task automatic run_step(input vec_t v);
        pressed = v.keys;
        if (v.pulse) exp_q.push_back(v.code);
        repeat (FRAME * v.frames) @(posedge clk);
        @(negedge clk);
        #1;
        check({v.name, "_pending"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        check({v.name, "_down"}, 32'(kp.key_down), 32'(v.down));
        check({v.name, "_code"}, 32'(kp.key_code), 32'(v.code));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1);
    end

    initial begin
        col_tab[0] = 4'b0111; col_tab[1] = 4'b1011;
        col_tab[2] = 4'b1101; col_tab[3] = 4'b1110;

        vecs.push_back(mk(16'h0000,          2, 1'b0, 4'd0,  1'b0, "idle"));
        vecs.push_back(mk(key(5),            2, 1'b1, 4'd5,  1'b1, "press5"));
        vecs.push_back(mk(key(5),           10, 1'b0, 4'd5,  1'b1, "hold5"));
        vecs.push_back(mk(16'h0000,          2, 1'b0, 4'd5,  1'b0, "release5"));
        for (int i = 0; i < 3; i++) begin
            vecs.push_back(mk(key(12),       1, 1'b0, 4'd5,  1'b0, "bounce_on"));
            vecs.push_back(mk(16'h0000,      1, 1'b0, 4'd5,  1'b0, "bounce_off"));
        end
        vecs.push_back(mk(key(12),           2, 1'b1, 4'd12, 1'b1, "hold12"));
        vecs.push_back(mk(16'h0000,          2, 1'b0, 4'd12, 1'b0, "release12"));
        vecs.push_back(mk(key(0) | key(15),  2, 1'b0, 4'd12, 1'b0, "multi_0_15"));
        vecs.push_back(mk(key(0),            2, 1'b1, 4'd0,  1'b1, "single0"));
        vecs.push_back(mk(key(9),            1, 1'b0, 4'd0,  1'b1, "roll9_first"));
        vecs.push_back(mk(key(9),            1, 1'b1, 4'd9,  1'b1, "roll9_second"));
        vecs.push_back(mk(key(4) | key(5),   2, 1'b0, 4'd9,  1'b0, "multi_samecol"));
        vecs.push_back(mk(key(10),           2, 1'b1, 4'd10, 1'b1, "key10"));
        vecs.push_back(mk(key(3),            2, 1'b1, 4'd3,  1'b1, "roll3"));
        vecs.push_back(mk(16'h0000,          2, 1'b0, 4'd3,  1'b0, "release3"));
        vecs.push_back(mk(key(5),            2, 1'b1, 4'd5,  1'b1, "pre_reset5"));

        pressed = 16'h0000;
        rst_n   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_col",   32'(kp.col),       32'(4'b0111));
        check("reset_valid", 32'(kp.key_valid), 32'd0);
        check("reset_code",  32'(kp.key_code),  32'd0);
        check("reset_down",  32'(kp.key_down),  32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < FRAME; i++) begin
            check("rotation_col", 32'(kp.col), 32'(col_tab[i/4]));
            check("rotation_valid", 32'(kp.key_valid), 32'd0);
            @(posedge clk);
            #1;
        end
        check("rotation_wrap_col", 32'(kp.col), 32'(4'b0111));

        for (int i = 0; i < vecs.size(); i++) begin
            run_step(vecs[i]);
        end

        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midreset_col",   32'(kp.col),       32'(4'b0111));
        check("midreset_valid", 32'(kp.key_valid), 32'd0);
        check("midreset_code",  32'(kp.key_code),  32'd0);
        check("midreset_down",  32'(kp.key_down),  32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_step(mk(key(5), 1, 1'b0, 4'd0, 1'b0, "postreset_first"));
        run_step(mk(key(5), 1, 1'b1, 4'd5, 1'b1, "postreset_second"));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
